// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the 68000 bus responder: state encoding,
// default decode constants and counter sizing.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_WAIT,
        ST_MEM_ACK,
        ST_VPA_CYC,
        ST_END_WAIT
    } state_t;

    localparam int         RAM_WAIT_DEF = 2;
    localparam int         TIMEOUT_DEF  = 255;
    localparam logic [3:0] VPA_PAGE_DEF = 4'hE;
    localparam logic [2:0] FC_AUTOVEC   = 3'b111;

    // Bits needed to hold the larger of two counts without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// 68000 bus signals seen by the responder: strobes, address, function
// code, E-clock sideband and the acknowledge lines driven back.
interface cpu_bus_responder_if;

    logic        cpu_en_p;
    logic        cpu_en_n;
    logic        _cpuAS;
    logic        _cpuUDS;
    logic        _cpuLDS;
    logic        _cpuRW;
    logic [2:0]  cpuFC;
    logic [23:1] cpuAddr;
    logic        _cpuVMA;
    logic        E_falling;
    logic        mem_ready;
    logic        _cpuDTACK;
    logic        _cpuVPA;
    logic        mem_sel;
    logic        via_strobe;
    logic        timeout;

    modport slave (
        input  cpu_en_p,
        input  cpu_en_n,
        input  _cpuAS,
        input  _cpuUDS,
        input  _cpuLDS,
        input  _cpuRW,
        input  cpuFC,
        input  cpuAddr,
        input  _cpuVMA,
        input  E_falling,
        input  mem_ready,
        output _cpuDTACK,
        output _cpuVPA,
        output mem_sel,
        output via_strobe,
        output timeout
    );

    modport master (
        output cpu_en_p,
        output cpu_en_n,
        output _cpuAS,
        output _cpuUDS,
        output _cpuLDS,
        output _cpuRW,
        output cpuFC,
        output cpuAddr,
        output _cpuVMA,
        output E_falling,
        output mem_ready,
        input  _cpuDTACK,
        input  _cpuVPA,
        input  mem_sel,
        input  via_strobe,
        input  timeout
    );

endinterface

// File: rtl/cpu_bus_responder.sv
// Responds to 68000 bus cycles: DTACK for memory with wait/timeout,
// VPA for the E-clock peripheral page and autovector acknowledges.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int         RAM_WAIT = RAM_WAIT_DEF,
    parameter int         TIMEOUT  = TIMEOUT_DEF,
    parameter logic [3:0] VPA_PAGE = VPA_PAGE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    cpu_bus_responder_if.slave bus
);

    localparam int CW = cnt_width(RAM_WAIT, TIMEOUT);
    localparam logic [CW-1:0] C_WAIT = CW'(RAM_WAIT);
    localparam logic [CW-1:0] C_TMO  = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_wait;
    logic [CW-1:0] w_wait_nx;
    logic [CW-1:0] r_tmo;
    logic [CW-1:0] w_tmo_nx;
    logic          r_avec;
    logic          w_avec_nx;
    logic          r_strobed;
    logic          w_strobed_nx;
    logic          r_dtack_n;
    logic          w_dtack_n_nx;
    logic          r_vpa_n;
    logic          w_vpa_n_nx;
    logic          r_mem_sel;
    logic          w_mem_sel_nx;
    logic          r_via;
    logic          w_via_nx;
    logic          r_tmo_p;
    logic          w_tmo_p_nx;

    logic w_as;
    logic w_avec_hit;
    logic w_vpa_hit;
    logic w_e_hit;
    logic w_unused;

    assign w_as       = !bus._cpuAS;
    assign w_avec_hit = (bus.cpuFC == FC_AUTOVEC);
    assign w_vpa_hit  = (bus.cpuAddr[23:20] == VPA_PAGE);
    assign w_e_hit    = bus.E_falling && !bus._cpuVMA;

    // Data-strobe, direction and low address bits do not affect the
    // acknowledge protocol.
    assign w_unused = &{1'b0, bus._cpuUDS, bus._cpuLDS, bus._cpuRW,
                        bus.cpu_en_n, bus.cpuAddr[19:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_END_WAIT;
            r_wait    <= '0;
            r_tmo     <= '0;
            r_avec    <= 1'b0;
            r_strobed <= 1'b0;
            r_dtack_n <= 1'b1;
            r_vpa_n   <= 1'b1;
            r_mem_sel <= 1'b0;
            r_via     <= 1'b0;
            r_tmo_p   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_wait    <= w_wait_nx;
            r_tmo     <= w_tmo_nx;
            r_avec    <= w_avec_nx;
            r_strobed <= w_strobed_nx;
            r_dtack_n <= w_dtack_n_nx;
            r_vpa_n   <= w_vpa_n_nx;
            r_mem_sel <= w_mem_sel_nx;
            r_via     <= w_via_nx;
            r_tmo_p   <= w_tmo_p_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_wait_nx    = r_wait;
        w_tmo_nx     = r_tmo;
        w_avec_nx    = r_avec;
        w_strobed_nx = r_strobed;
        w_dtack_n_nx = 1'b1;
        w_vpa_n_nx   = 1'b1;
        w_mem_sel_nx = 1'b0;
        w_via_nx     = 1'b0;
        w_tmo_p_nx   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_as) begin
                    w_strobed_nx = 1'b0;
                    w_wait_nx    = C_WAIT;
                    w_tmo_nx     = '0;
                    // Autovector wins over the peripheral page.
                    if (w_avec_hit) begin
                        w_state_nx = ST_VPA_CYC;
                        w_avec_nx  = 1'b1;
                        w_vpa_n_nx = 1'b0;
                    end else if (w_vpa_hit) begin
                        w_state_nx = ST_VPA_CYC;
                        w_avec_nx  = 1'b0;
                        w_vpa_n_nx = 1'b0;
                    end else begin
                        w_state_nx   = ST_MEM_WAIT;
                        w_avec_nx    = 1'b0;
                        w_mem_sel_nx = 1'b1;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (!w_as) begin
                    w_state_nx = ST_IDLE;
                    w_wait_nx  = '0;
                    w_tmo_nx   = '0;
                end else begin
                    w_mem_sel_nx = 1'b1;
                    if (r_wait == '0 && bus.mem_ready) begin
                        w_state_nx   = ST_MEM_ACK;
                        w_dtack_n_nx = 1'b0;
                    end else if (r_tmo >= C_TMO) begin
                        w_state_nx   = ST_MEM_ACK;
                        w_dtack_n_nx = 1'b0;
                        w_tmo_p_nx   = 1'b1;
                    end else if (bus.cpu_en_p) begin
                        if (r_wait != '0) begin
                            w_wait_nx = r_wait - C_ONE;
                        end
                        w_tmo_nx = r_tmo + C_ONE;
                    end
                end
            end

            ST_MEM_ACK: begin
                if (!w_as) begin
                    w_state_nx = ST_IDLE;
                    w_wait_nx  = '0;
                    w_tmo_nx   = '0;
                end else begin
                    w_dtack_n_nx = 1'b0;
                    w_mem_sel_nx = 1'b1;
                end
            end

            ST_VPA_CYC: begin
                if (!w_as) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_vpa_n_nx = 1'b0;
                    // One peripheral access per bus cycle.
                    if (!r_avec && !r_strobed && w_e_hit) begin
                        w_via_nx     = 1'b1;
                        w_strobed_nx = 1'b1;
                    end
                end
            end

            ST_END_WAIT: begin
                if (!w_as) begin
                    w_state_nx = ST_IDLE;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus._cpuDTACK  = r_dtack_n;
    assign bus._cpuVPA    = r_vpa_n;
    assign bus.mem_sel    = r_mem_sel;
    assign bus.via_strobe = r_via;
    assign bus.timeout    = r_tmo_p;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: directed bus cycles plus randomized
// traffic, checked every cycle against a cycle-level behavioural model.
module tb_cpu_bus_responder;

    localparam int RW = 2;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu_bus_responder_if bus();

    cpu_bus_responder #(
        .RAM_WAIT(RW),
        .TIMEOUT (TO),
        .VPA_PAGE(4'hE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: kind 0 none, 1 memory, 2 peripheral, 3 autovector.
    int   m_kind    = 0;
    bit   m_blocked = 1'b1;
    int   m_n       = 0;
    bit   m_acked   = 1'b0;
    bit   m_strobed = 1'b0;
    logic e_dtack   = 1'b1;
    logic e_vpa     = 1'b1;
    logic e_msel    = 1'b0;
    logic e_via     = 1'b0;
    logic e_tmo     = 1'b0;

    always @(posedge clk) begin
        e_via = 1'b0;
        e_tmo = 1'b0;
        if (reset) begin
            m_blocked = 1'b1;
            m_kind    = 0;
        end else if (m_blocked) begin
            if (bus._cpuAS) m_blocked = 1'b0;
        end else if (m_kind == 0) begin
            if (!bus._cpuAS) begin
                if (bus.cpuFC == 3'd7) m_kind = 3;
                else if (bus.cpuAddr[23:20] == 4'hE) m_kind = 2;
                else m_kind = 1;
                m_n       = 0;
                m_acked   = 1'b0;
                m_strobed = 1'b0;
            end
        end else if (bus._cpuAS) begin
            m_kind = 0;
        end else if (m_kind == 1) begin
            if (!m_acked) begin
                if (m_n >= RW && bus.mem_ready) begin
                    m_acked = 1'b1;
                end else if (m_n >= TO) begin
                    m_acked = 1'b1;
                    e_tmo   = 1'b1;
                end else if (bus.cpu_en_p) begin
                    m_n++;
                end
            end
        end else if (m_kind == 2) begin
            if (!m_strobed && bus.E_falling && !bus._cpuVMA) begin
                m_strobed = 1'b1;
                e_via     = 1'b1;
            end
        end
        e_dtack = !(m_kind == 1 && m_acked);
        e_vpa   = !(m_kind >= 2);
        e_msel  = (m_kind == 1);
    end

    always @(negedge clk) begin
        chk("dtack", bus._cpuDTACK, e_dtack);
        chk("vpa", bus._cpuVPA, e_vpa);
        chk("mem_sel", bus.mem_sel, e_msel);
        chk("via_strobe", bus.via_strobe, e_via);
        chk("timeout", bus.timeout, e_tmo);
        chk("dtack_vpa_excl", bus._cpuDTACK | bus._cpuVPA, 1'b1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [23:1] wa(input logic [23:0] a);
        return a[23:1];
    endfunction

    task automatic idle_bus();
        bus._cpuAS    = 1'b1;
        bus._cpuUDS   = 1'b1;
        bus._cpuLDS   = 1'b1;
        bus._cpuRW    = 1'b1;
        bus.cpu_en_p  = 1'b0;
        bus.cpu_en_n  = 1'b0;
        bus.E_falling = 1'b0;
        bus._cpuVMA   = 1'b1;
        bus.mem_ready = 1'b0;
        bus.cpuFC     = 3'b101;
        bus.cpuAddr   = '0;
    endtask

    int ens;
    int first;
    int pulses;
    int tmo_at_ack;
    int vpa_low;
    int dt_low;
    int strobes;

    initial begin
        idle_bus();
        reset = 1'b1;
        step();
        step();
        chk("rst_dtack", bus._cpuDTACK, 1'b1);
        chk("rst_vpa", bus._cpuVPA, 1'b1);
        chk("rst_mem_sel", bus.mem_sel, 1'b0);
        chk("rst_via", bus.via_strobe, 1'b0);
        chk("rst_timeout", bus.timeout, 1'b0);
        reset = 1'b0;
        step();
        step();

        // Memory read, ready tied high
        bus.cpuAddr   = wa(24'h000100);
        bus.mem_ready = 1'b1;
        bus._cpuUDS   = 1'b0;
        bus._cpuLDS   = 1'b0;
        bus._cpuAS    = 1'b0;
        ens   = 0;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            bus.cpu_en_p = (i % 3 == 0);
            step();
            if (bus.cpu_en_p) ens++;
            if (first < 0 && bus._cpuDTACK == 1'b0) first = ens;
        end
        chk_int("ram_wait_en_count", first, 2);
        chk("dtack_held", bus._cpuDTACK, 1'b0);
        bus._cpuAS   = 1'b1;
        bus.cpu_en_p = 1'b0;
        step();
        chk("dtack_release", bus._cpuDTACK, 1'b1);
        chk("mem_sel_release", bus.mem_sel, 1'b0);
        step();

        // Memory cycle that never gets ready
        bus.mem_ready = 1'b0;
        bus._cpuAS    = 1'b0;
        ens        = 0;
        first      = -1;
        pulses     = 0;
        tmo_at_ack = 0;
        for (int i = 1; i <= 600 && first < 0; i++) begin
            bus.cpu_en_p = (i % 2 == 0);
            step();
            if (bus.cpu_en_p) ens++;
            if (bus.timeout) pulses++;
            if (bus._cpuDTACK == 1'b0) begin
                first      = ens;
                tmo_at_ack = int'(bus.timeout);
            end
        end
        chk_int("timeout_en_count", first, 255);
        chk_int("timeout_with_dtack", tmo_at_ack, 1);
        bus.cpu_en_p = 1'b0;
        repeat (4) begin
            step();
            if (bus.timeout) pulses++;
        end
        chk_int("timeout_pulses", pulses, 1);
        bus._cpuAS = 1'b1;
        step();
        step();

        // Peripheral page access with three E falling edges
        bus.cpuAddr = wa(24'hEFE1FE);
        bus.cpuFC   = 3'b101;
        bus._cpuVMA = 1'b0;
        bus._cpuAS  = 1'b0;
        vpa_low = 0;
        dt_low  = 0;
        strobes = 0;
        for (int i = 1; i <= 20; i++) begin
            bus.E_falling = (i == 5 || i == 10 || i == 15);
            step();
            if (!bus._cpuVPA) vpa_low++;
            if (!bus._cpuDTACK) dt_low++;
            if (bus.via_strobe) strobes++;
        end
        chk_int("vpa_low_cycles", vpa_low, 20);
        chk_int("vpa_dtack_low", dt_low, 0);
        chk_int("via_strobes", strobes, 1);
        bus.E_falling = 1'b0;
        bus._cpuAS    = 1'b1;
        step();
        chk("vpa_release", bus._cpuVPA, 1'b1);
        step();

        // Autovector acknowledge inside the peripheral page
        bus.cpuAddr = wa(24'hEFFFFF);
        bus.cpuFC   = 3'b111;
        bus._cpuAS  = 1'b0;
        vpa_low = 0;
        strobes = 0;
        for (int i = 1; i <= 12; i++) begin
            bus.E_falling = (i % 4 == 0);
            step();
            if (!bus._cpuVPA) vpa_low++;
            if (bus.via_strobe) strobes++;
        end
        chk_int("avec_vpa_low", vpa_low, 12);
        chk_int("avec_strobes", strobes, 0);
        bus.E_falling = 1'b0;
        bus._cpuAS    = 1'b1;
        bus._cpuVMA   = 1'b1;
        bus.cpuFC     = 3'b101;
        step();
        step();

        // Reset in the middle of a memory wait, strobe held low
        bus.cpuAddr   = wa(24'h000200);
        bus.mem_ready = 1'b0;
        bus.cpu_en_p  = 1'b1;
        bus._cpuAS    = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        chk("midrst_dtack", bus._cpuDTACK, 1'b1);
        chk("midrst_mem_sel", bus.mem_sel, 1'b0);
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        dt_low = 0;
        repeat (20) begin
            step();
            if (!bus._cpuDTACK) dt_low++;
        end
        chk_int("stale_cycle_dtack", dt_low, 0);
        bus._cpuAS = 1'b1;
        step();
        bus._cpuAS = 1'b0;
        first = -1;
        for (int i = 1; i <= 30 && first < 0; i++) begin
            step();
            if (!bus._cpuDTACK) first = i;
        end
        chk_int("post_reset_ack_cycle", first, 4);
        bus._cpuAS   = 1'b1;
        bus.cpu_en_p = 1'b0;
        step();
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 120; c++) begin
            logic [23:0] a;
            a = 24'($urandom);
            if ($urandom % 3 == 0) a[23:20] = 4'hE;
            bus.cpuAddr = wa(a);
            bus.cpuFC   = ($urandom % 5 == 0) ? 3'd7 : 3'($urandom % 7);
            bus._cpuRW  = 1'($urandom);
            bus._cpuUDS = 1'($urandom);
            bus._cpuLDS = 1'($urandom);
            bus._cpuAS  = 1'b0;
            for (int j = 0, n = $urandom_range(1, 30); j < n; j++) begin
                bus.cpu_en_p  = ($urandom % 3 == 0);
                bus.cpu_en_n  = 1'($urandom);
                bus.mem_ready = ($urandom % 4 != 0);
                bus.E_falling = ($urandom % 6 == 0);
                bus._cpuVMA   = 1'($urandom);
                reset         = ($urandom % 60 == 0);
                step();
            end
            reset      = 1'b0;
            bus._cpuAS = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                bus.cpu_en_p  = ($urandom % 3 == 0);
                bus.E_falling = ($urandom % 6 == 0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
